uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Parametrised UART receiver with an integrated receive FIFO, the next-generation replacement for the single-byte receiver on the host serial link. It adds configurable frame format (data width, parity, stop bits), an input synchroniser, 3-sample majority voting, false-start rejection, break detection and a valid/ready output stream. It sits between the board RX pin and the loader/MMIO logic that drains received bytes.

## Interface
- CLK_PER_HALF_BIT, 5208, clk cycles per half bit period; bit period = 2*CLK_PER_HALF_BIT; minimum 4
- DATA_BITS, 8, data bits per frame, 5..8
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, 1 or 2
- FIFO_DEPTH, 16, receive FIFO entries, power of two, at least 2

- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- rxd  in  1  asynchronous serial input, idle high
- m_data  out  DATA_BITS  head-of-FIFO data, LSB = first received bit
- m_perr  out  1  parity error flag stored with the m_data entry; 0 when PARITY = 0
- m_ferr  out  1  framing error flag stored with the m_data entry
- m_valid  out  1  FIFO non-empty
- m_ready  in  1  consumer accepts the head entry when m_valid && m_ready
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy
- overrun  out  1  sticky; set when a frame is dropped because the FIFO is full
- clr_err  in  1  clears overrun
- break_det  out  1  one-cycle pulse on a break condition

## Operation
- rxd passes through a 2-flop synchroniser whose flops reset to 1. All logic uses the synchronised signal rxs.
- Majority sample: at each bit centre, the bit value is the majority of rxs at counter values CLK_PER_HALF_BIT-2, -1 and 0 relative to the centre.
- States (enum in package):
  - IDLE: the bit counter is cleared on the rxs high-to-low transition; go to START.
  - START: at mid-bit, a majority of 1 is a false start and returns to IDLE with nothing pushed. A majority of 0 goes to DATA.
  - DATA: shift in DATA_BITS samples, LSB first, one per bit period. Then go to PARITY if PARITY != 0, otherwise STOP.
  - PARITY: sample the parity bit. perr = 1 if the received parity mismatches the configured odd/even rule.
  - STOP: sample each of STOP_BITS stop bits. ferr = 1 if any stop sample is 0. At the mid-sample of the last stop bit, perform frame completion and go to IDLE (resync at mid-stop).
  - BRK_WAIT: wait until rxs = 1, then go to IDLE.
- Frame completion:
  - Break condition: all data samples, the parity sample (if any) and the first stop sample are 0. Pulse break_det, do not push, go to BRK_WAIT.
  - Otherwise, push {ferr, perr, data} into the FIFO.
- FIFO full:
  - A push succeeds if count < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the new frame is dropped, overrun is set, and FIFO contents are unchanged.
- overrun stays set until a clr_err cycle. If a set and a clear occur in the same cycle, set wins.
- Simultaneous push and pop leaves fifo_count unchanged. The pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values: m_valid = 0, m_data = 0, m_perr = 0, m_ferr = 0, fifo_count = 0, overrun = 0, break_det = 0; state = IDLE; synchroniser = 1.
- Reset mid-frame aborts the frame. Nothing is pushed and the FIFO is emptied.
- Input latency: 2 cycles of synchroniser delay.
- m_valid rises 1 cycle after the push cycle (first-word fall-through, registered outputs).
- Pop takes effect on the clock edge where m_valid && m_ready. The next entry is presented in the following cycle with no bubble.
- m_data, m_perr and m_ferr are stable while m_valid && !m_ready.
- Back-to-back frames with zero idle time are received without loss, because the receiver returns to IDLE at mid-stop.

## Structure
- Package uart_pkg:
  - parity_e (PAR_NONE, PAR_ODD, PAR_EVEN)
  - rx_state_e
  - function clog2-based width helper
- Sub-module sync_fifo (parameters WIDTH, DEPTH): push/pop, full/empty, count, first-word fall-through. Instantiated with WIDTH = DATA_BITS+2.
- The receive FSM, bit counter, majority voter and synchroniser live in uart_rx_fifo.

## Test plan
- Defaults, CLK_PER_HALF_BIT=4, send 0xA5 then 0x3C back-to-back with m_ready=1 -> two entries 0xA5, 0x3C, perr=0, ferr=0.
- PARITY=2 (even), send 0x07 with parity bit 0 -> entry 0x07 with perr=1. With parity bit 1 -> perr=0.
- Stop bit forced 0 on 0x55 -> entry 0x55 with ferr=1. A 1-sample glitch low on rxd in idle -> no entry, state back to IDLE.
- m_ready=0, send FIFO_DEPTH+1 frames -> fifo_count=16, overrun=1, first 16 bytes intact. clr_err -> overrun=0.
- Hold rxd low for 2 frame times -> break_det pulses once, no entry. Then rxd high and send 0x81 -> entry 0x81.
- Assert reset_n=0 mid-data-bit with 3 entries queued -> all outputs at reset values; next full frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receiver slice.
//   parity_e   : parity configuration encoding (none / odd / even)
//   rx_state_e : receive FSM states
//   width_of() : counter/pointer width for a range of n values (minimum 1)
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BRK_WAIT
  } rx_state_e;

  // Bits needed to hold the values 0..n-1.
  function automatic int unsigned width_of(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered head output.
//   clk, reset_n : clock, synchronous active-low reset (empties the FIFO)
//   push, din    : write request and data; accepted when not full or when a
//                  pop happens in the same cycle
//   pop          : consume the head entry (ignored when empty)
//   dout         : head entry, zero when empty, stable until popped
//   full, empty  : occupancy flags
//   count        : current occupancy, 0..DEPTH
module sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = width_of(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = dout_q;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    dout_d   = dout_q;
    // The head after this edge is either the entry just being written (FIFO
    // drains to nothing before the write) or an entry already in memory.
    if ((count_q - CW'(do_pop)) == '0) begin
      dout_d = do_push ? din : '0;
    end else begin
      dout_d = mem_q[rd_ptr_d];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // their inputs from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; emptiness is tracked
  // by the pointers and count, and the output register masks stale contents.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable frame format and an integrated receive FIFO.
//   clk, reset_n          : clock, synchronous active-low reset
//   rxd                   : asynchronous serial input, idle high
//   m_data/m_perr/m_ferr  : head-of-FIFO frame and its error flags
//   m_valid, m_ready      : output stream handshake
//   fifo_count            : FIFO occupancy
//   overrun, clr_err      : sticky dropped-frame flag and its clear
//   break_det             : one-cycle pulse when a break is recognised
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_PER_HALF_BIT = 5208,
  parameter int unsigned DATA_BITS        = 8,
  parameter int unsigned PARITY           = 0,
  parameter int unsigned STOP_BITS        = 1,
  parameter int unsigned FIFO_DEPTH       = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          rxd,
  output logic [DATA_BITS-1:0]          m_data,
  output logic                          m_perr,
  output logic                          m_ferr,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun,
  input  logic                          clr_err,
  output logic                          break_det
);

  localparam int unsigned CW = width_of(2 * CLK_PER_HALF_BIT);
  localparam int unsigned IW = width_of(DATA_BITS);
  localparam int unsigned FW = DATA_BITS + 2;

  localparam parity_e       PAR_CFG   = parity_e'(2'(PARITY));
  localparam logic [CW-1:0] HALF_END  = CW'(CLK_PER_HALF_BIT - 1);
  localparam logic [CW-1:0] FULL_END  = CW'(2 * CLK_PER_HALF_BIT - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

  // Synchroniser plus two history flops for the 3-sample majority vote.
  logic sync1_q, rxs, rxs_d1_q, rxs_d2_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q  <= 1'b1;
      rxs      <= 1'b1;
      rxs_d1_q <= 1'b1;
      rxs_d2_q <= 1'b1;
    end else begin
      sync1_q  <= rxd;
      rxs      <= sync1_q;
      rxs_d1_q <= rxs;
      rxs_d2_q <= rxs_d1_q;
    end
  end

  logic maj, fall;
  assign maj  = (rxs & rxs_d1_q) | (rxs & rxs_d2_q) | (rxs_d1_q & rxs_d2_q);
  assign fall = rxs_d1_q & ~rxs;

  rx_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 brk_q, brk_d;     // every sample so far has been 0
  logic                 break_det_q, break_det_d;
  logic                 overrun_q, overrun_d;
  logic                 push, ferr_now, brk_now, mid;

  logic [FW-1:0]        fifo_dout;
  logic                 fifo_full, fifo_empty, drop;

  // Mid-bit point: half a bit after the start edge, then once per bit period.
  assign mid = (state_q == S_START) ? (cnt_q == HALF_END) : (cnt_q == FULL_END);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    idx_d       = idx_q;
    shreg_d     = shreg_q;
    perr_d      = perr_q;
    ferr_d      = ferr_q;
    brk_d       = brk_q;
    push        = 1'b0;
    break_det_d = 1'b0;
    ferr_now    = ferr_q | ~maj;
    brk_now     = (idx_q == '0) ? (brk_q & ~maj) : brk_q;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (fall) begin
          state_d = S_START;
          idx_d   = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
          brk_d   = 1'b1;
        end
      end
      S_START: begin
        if (mid) begin
          cnt_d   = '0;
          state_d = maj ? S_IDLE : S_DATA;   // high at mid-start is a glitch
        end
      end
      S_DATA: begin
        if (mid) begin
          cnt_d   = '0;
          shreg_d = {maj, shreg_q[DATA_BITS-1:1]};   // LSB arrives first
          brk_d   = brk_q & ~maj;
          if (idx_q == DATA_LAST) begin
            idx_d   = '0;
            state_d = (PAR_CFG == PAR_NONE) ? S_STOP : S_PARITY;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_PARITY: begin
        if (mid) begin
          cnt_d   = '0;
          // Even: ones in data+parity must be even; odd flips the rule.
          perr_d  = (^shreg_q) ^ maj ^ (PAR_CFG == PAR_ODD);
          brk_d   = brk_q & ~maj;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (mid) begin
          cnt_d  = '0;
          ferr_d = ferr_now;
          brk_d  = brk_now;          // only the first stop sample counts
          if (idx_q == STOP_LAST) begin
            if (brk_now) begin
              break_det_d = 1'b1;
              state_d     = S_BRK_WAIT;
            end else begin
              push    = 1'b1;
              state_d = S_IDLE;      // resync at mid-stop for back-to-back frames
            end
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_BRK_WAIT: begin
        cnt_d = '0;
        if (rxs) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Set wins over a simultaneous clear.
    overrun_d = drop | (overrun_q & ~clr_err);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shreg_q     <= '0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      brk_q       <= 1'b0;
      break_det_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      brk_q       <= brk_d;
      break_det_q <= break_det_d;
      overrun_q   <= overrun_d;
    end
  end

  // A frame is dropped only when full and the consumer is not freeing a slot.
  assign drop = push && fifo_full && !(m_valid && m_ready);

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .din     ({ferr_now, perr_q, shreg_q}),
    .pop     (m_ready),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign m_data    = fifo_dout[DATA_BITS-1:0];
  assign m_perr    = fifo_dout[DATA_BITS];
  assign m_ferr    = fifo_dout[DATA_BITS+1];
  assign m_valid   = ~fifo_empty;
  assign overrun   = overrun_q;
  assign break_det = break_det_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: one instance without parity and one
// with even parity, both at CLK_PER_HALF_BIT=4. Expected frames are queued as
// they are driven and compared when the DUT hands them out.
module tb_uart_rx_fifo;

  localparam int H     = 4;
  localparam int BP    = 2 * H;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rxd = 1'b1, rxd_p = 1'b1;
  logic       m_ready = 1'b0, m_ready_p = 1'b1;
  logic       clr_err = 1'b0, clr_err_p = 1'b0;

  logic [7:0] m_data, m_data_p;
  logic       m_perr, m_perr_p, m_ferr, m_ferr_p, m_valid, m_valid_p;
  logic [4:0] fifo_count, fifo_count_p;
  logic       overrun, overrun_p, break_det, break_det_p;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLK_PER_HALF_BIT(H), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .rxd(rxd),
    .m_data(m_data), .m_perr(m_perr), .m_ferr(m_ferr), .m_valid(m_valid),
    .m_ready(m_ready), .fifo_count(fifo_count), .overrun(overrun),
    .clr_err(clr_err), .break_det(break_det)
  );

  uart_rx_fifo #(
    .CLK_PER_HALF_BIT(H), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)
  ) dut_p (
    .clk(clk), .reset_n(reset_n), .rxd(rxd_p),
    .m_data(m_data_p), .m_perr(m_perr_p), .m_ferr(m_ferr_p), .m_valid(m_valid_p),
    .m_ready(m_ready_p), .fifo_count(fifo_count_p), .overrun(overrun_p),
    .clr_err(clr_err_p), .break_det(break_det_p)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_pops   = 0;
  int brk_cnt  = 0;
  logic [9:0] sb_q[$];      // {ferr, perr, data}
  logic [9:0] sb_p_q[$];
  logic [9:0] exp_e, exp_p;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitors: a transfer happens at the next rising edge.
  always @(negedge clk) begin
    if (reset_n && m_valid && m_ready) begin
      n_pops++;
      check("sb_pending", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        exp_e = sb_q.pop_front();
        check("sb_data", 32'(m_data), 32'(exp_e[7:0]));
        check("sb_perr", 32'(m_perr), 32'(exp_e[8]));
        check("sb_ferr", 32'(m_ferr), 32'(exp_e[9]));
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && m_valid_p && m_ready_p) begin
      check("sbp_pending", 32'(sb_p_q.size() != 0), 32'd1);
      if (sb_p_q.size() != 0) begin
        exp_p = sb_p_q.pop_front();
        check("sbp_data", 32'(m_data_p), 32'(exp_p[7:0]));
        check("sbp_perr", 32'(m_perr_p), 32'(exp_p[8]));
        check("sbp_ferr", 32'(m_ferr_p), 32'(exp_p[9]));
      end
    end
  end

  always @(negedge clk) begin
    if (break_det) brk_cnt++;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic drive_bit(input bit p, input logic v);
    if (p) rxd_p = v; else rxd = v;
    repeat (BP) @(posedge clk);
  endtask

  // Drives one frame; the parity bit is only sent on the parity instance.
  task automatic send_frame(input bit p, input logic [7:0] d, input logic par_bit,
                            input logic stop_v, input bit expect_push);
    if (expect_push) begin
      if (p) sb_p_q.push_back({~stop_v, (^d) ^ par_bit, d});
      else   sb_q.push_back({~stop_v, 1'b0, d});
    end
    drive_bit(p, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(p, d[i]);
    if (p) drive_bit(p, par_bit);
    drive_bit(p, stop_v);
  endtask

  task automatic wait_drain(input bit p);
    for (int i = 0; i < 4000; i++) begin
      if ((p ? sb_p_q.size() : sb_q.size()) == 0) break;
      @(posedge clk);
    end
    idle(2);
    check(p ? "drain_p" : "drain", 32'(p ? sb_p_q.size() : sb_q.size()), 32'd0);
  endtask

  task automatic check_reset_values();
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_data", 32'(m_data), 32'd0);
    check("rst_perr", 32'(m_perr), 32'd0);
    check("rst_ferr", 32'(m_ferr), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_break", 32'(break_det), 32'd0);
  endtask

  int pops0, brk0;

  initial begin
    // Reset state
    idle(3);
    @(negedge clk);
    check_reset_values();
    @(posedge clk);
    reset_n = 1'b1;
    idle(4 * BP);

    // Back-to-back frames
    m_ready = 1'b1;
    send_frame(0, 8'hA5, 1'b0, 1'b1, 1'b1);
    send_frame(0, 8'h3C, 1'b0, 1'b1, 1'b1);
    wait_drain(0);
    check("b2b_pops", 32'(n_pops), 32'd2);

    // Even parity: 0x07 has three ones, so parity bit 0 is wrong, 1 is right
    send_frame(1, 8'h07, 1'b0, 1'b1, 1'b1);
    send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
    wait_drain(1);

    // Framing error
    send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1);
    rxd = 1'b1;
    idle(2 * BP);
    wait_drain(0);

    // One-cycle glitch in idle produces nothing, next frame still received
    pops0 = n_pops;
    @(posedge clk); rxd = 1'b0;
    @(posedge clk); rxd = 1'b1;
    idle(4 * BP);
    check("glitch_pops", 32'(n_pops), 32'(pops0));
    check("glitch_count", 32'(fifo_count), 32'd0);
    send_frame(0, 8'h5A, 1'b0, 1'b1, 1'b1);
    wait_drain(0);

    // Overrun: DEPTH+1 frames with no consumer, the last one is dropped
    m_ready = 1'b0;
    for (int i = 0; i <= DEPTH; i++)
      send_frame(0, 8'(i * 13 + 7), 1'b0, 1'b1, i < DEPTH);
    idle(BP);
    check("ovr_count", 32'(fifo_count), 32'd16);
    check("ovr_flag", 32'(overrun), 32'd1);
    check("ovr_hold0", 32'(m_data), 32'(sb_q[0][7:0]));
    idle(5);
    check("ovr_hold1", 32'(m_data), 32'(sb_q[0][7:0]));
    check("ovr_sticky", 32'(overrun), 32'd1);
    @(posedge clk); clr_err = 1'b1;
    @(posedge clk); clr_err = 1'b0;
    @(negedge clk);
    check("ovr_clear", 32'(overrun), 32'd0);
    m_ready = 1'b1;
    wait_drain(0);
    check("ovr_empty", 32'(fifo_count), 32'd0);

    // Break: line low for two frame times
    pops0 = n_pops;
    brk0  = brk_cnt;
    rxd = 1'b0;
    idle(20 * BP);
    rxd = 1'b1;
    idle(2 * BP);
    check("brk_pulses", 32'(brk_cnt - brk0), 32'd1);
    check("brk_pops", 32'(n_pops), 32'(pops0));
    send_frame(0, 8'h81, 1'b0, 1'b1, 1'b1);
    wait_drain(0);

    // Reset in the middle of a data bit with three entries queued
    m_ready = 1'b0;
    send_frame(0, 8'h11, 1'b0, 1'b1, 1'b1);
    send_frame(0, 8'h22, 1'b0, 1'b1, 1'b1);
    send_frame(0, 8'h33, 1'b0, 1'b1, 1'b1);
    idle(BP);
    check("pre_rst_count", 32'(fifo_count), 32'd3);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    rxd = 1'b0;
    idle(BP / 2);
    reset_n = 1'b0;
    rxd = 1'b1;
    idle(2);
    @(negedge clk);
    check_reset_values();
    sb_q.delete();
    @(posedge clk);
    reset_n = 1'b1;
    idle(2 * BP);
    m_ready = 1'b1;
    send_frame(0, 8'hC3, 1'b0, 1'b1, 1'b1);
    wait_drain(0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
